velocity_cell_ctrl: RTL and testbench

VELOCITY_CELL_CTRL -- requirements
Module: velocity_cell_ctrl

---
 rtl/velocity_cell_ctrl_if.sv | 55 +++++
 rtl/velocity_cell_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_velocity_cell_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/velocity_cell_ctrl_if.sv
// Bus bundle between the velocity cell controller, its cell memory,
// the motion-update unit and the host initialisation port.
//
// Handshakes (vel_out and vel_in): a word moves on a rising clock edge where
// both valid and ready are high. The sender holds valid and its payload
// stable until that edge. Valid never depends combinationally on ready.
// The host write port is a request/ack pair instead. The host holds
// host_wr_req, host_addr and host_data until it sees host_wr_ack. It then
// drops the request or presents the next one.
interface velocity_cell_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  logic [DATA_WIDTH-1:0] vel_out;
  logic [ADDR_WIDTH-1:0] vel_out_id;
  logic                  vel_out_valid;
  logic                  vel_out_ready;

  logic [DATA_WIDTH-1:0] vel_in;
  logic                  vel_in_valid;
  logic                  vel_in_ready;

  logic                  host_wr_req;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_wr_ack;

  modport master (
    output mem_address, mem_data, mem_rden, mem_wren,
    input  mem_q,
    output vel_out, vel_out_id, vel_out_valid,
    input  vel_out_ready,
    input  vel_in, vel_in_valid,
    output vel_in_ready,
    input  host_wr_req, host_addr, host_data,
    output host_wr_ack
  );

  modport slave (
    input  mem_address, mem_data, mem_rden, mem_wren,
    output mem_q,
    input  vel_out, vel_out_id, vel_out_valid,
    output vel_out_ready,
    output vel_in, vel_in_valid,
    input  vel_in_ready,
    output host_wr_req, host_addr, host_data,
    input  host_wr_ack
  );
endinterface

// File: rtl/velocity_cell_ctrl.sv
// Velocity cell controller. Address 0 of the cell memory holds the particle
// count N. A pass reads each velocity 1..N and sends it to the motion-update
// unit. It then writes the returned velocity back in place. While idle, the
// host can initialise the memory.
// Every strobe and bus output is registered. Its value is computed from the
// next state, so it lines up with the state it belongs to.
module velocity_cell_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LAT       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                count_err,
  output logic [3:0]          state_dbg,
  velocity_cell_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_CNT   = 4'd1,
    WAIT_CNT = 4'd2,
    RD_VEL   = 4'd3,
    WAIT_VEL = 4'd4,
    SEND     = 4'd5,
    RECV     = 4'd6,
    WR       = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCW-1:0]        WAIT_LAST = WCW'(RD_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ID    = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ID  = ADDR_WIDTH'(1);

  state_t                state, state_n;
  logic [WCW-1:0]        wait_cnt;
  logic                  wait_last;
  logic [ADDR_WIDTH-1:0] p, p_n;
  logic [ADDR_WIDTH-1:0] n_cnt, n_n;
  logic [ADDR_WIDTH-1:0] raw_cnt;
  logic                  err_n;
  logic                  rden_n, wren_n, ack_n, vout_load;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  busy_n, done_n, vov_n, vir_n;

  assign state_dbg = state;
  assign wait_last = (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, pointer/count updates and next values of registered outputs.
  always_comb begin
    state_n   = state;
    p_n       = p;
    n_n       = n_cnt;
    err_n     = count_err;
    rden_n    = 1'b0;
    wren_n    = 1'b0;
    ack_n     = 1'b0;
    addr_n    = '0;
    data_n    = '0;
    vout_load = 1'b0;
    raw_cnt   = bus.mem_q[ADDR_WIDTH-1:0];

    case (state)
      IDLE: begin
        // The host wins over start. A request that is already being acked
        // is not taken twice.
        if (bus.host_wr_req) begin
          if (!bus.host_wr_ack) begin
            wren_n = 1'b1;
            ack_n  = 1'b1;
            addr_n = bus.host_addr;
            data_n = bus.host_data;
          end
        end else if (start) begin
          state_n = RD_CNT;
          p_n     = FIRST_ID;
        end
      end
      RD_CNT:   state_n = WAIT_CNT;
      WAIT_CNT: begin
        if (wait_last) begin
          if (raw_cnt > MAX_ID) begin
            n_n   = MAX_ID;
            err_n = 1'b1;
          end else begin
            n_n = raw_cnt;
          end
          state_n = (raw_cnt == '0) ? DONE : RD_VEL;
        end
      end
      RD_VEL:   state_n = WAIT_VEL;
      WAIT_VEL: begin
        if (wait_last) begin
          vout_load = 1'b1;
          state_n   = SEND;
        end
      end
      SEND: if (bus.vel_out_valid && bus.vel_out_ready) state_n = RECV;
      RECV: if (bus.vel_in_valid && bus.vel_in_ready)   state_n = WR;
      WR: begin
        if (p == n_cnt) begin
          state_n = DONE;
        end else begin
          p_n     = p + FIRST_ID;
          state_n = RD_VEL;
        end
      end
      DONE: begin
        // A host request held pending through the pass is served in the
        // first IDLE cycle.
        state_n = IDLE;
        if (bus.host_wr_req) begin
          wren_n = 1'b1;
          ack_n  = 1'b1;
          addr_n = bus.host_addr;
          data_n = bus.host_data;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      RD_CNT: rden_n = 1'b1;
      RD_VEL: begin
        rden_n = 1'b1;
        addr_n = p_n;
      end
      WR: begin
        wren_n = 1'b1;
        addr_n = p;
        data_n = bus.vel_in;
      end
      default: ;
    endcase

    busy_n = !(state_n inside {IDLE, DONE});
    done_n = (state_n == DONE);
    vov_n  = (state_n == SEND);
    vir_n  = (state_n == RECV);
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt          <= '0;
      p                 <= FIRST_ID;
      n_cnt             <= '0;
      count_err         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.mem_rden      <= 1'b0;
      bus.mem_wren      <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_data      <= '0;
      bus.host_wr_ack   <= 1'b0;
      bus.vel_out_valid <= 1'b0;
      bus.vel_in_ready  <= 1'b0;
      bus.vel_out       <= '0;
      bus.vel_out_id    <= '0;
    end else begin
      wait_cnt          <= ((state_n == state) && (state inside {WAIT_CNT, WAIT_VEL}))
                           ? wait_cnt + WCW'(1) : '0;
      p                 <= p_n;
      n_cnt             <= n_n;
      count_err         <= err_n;
      busy              <= busy_n;
      done              <= done_n;
      bus.mem_rden      <= rden_n;
      bus.mem_wren      <= wren_n;
      bus.mem_address   <= addr_n;
      bus.mem_data      <= data_n;
      bus.host_wr_ack   <= ack_n;
      bus.vel_out_valid <= vov_n;
      bus.vel_in_ready  <= vir_n;
      if (vout_load) begin
        bus.vel_out    <= bus.mem_q;
        bus.vel_out_id <= p;
      end
    end
  end

endmodule

// File: tb/tb_velocity_cell_ctrl.sv
// Bench for velocity_cell_ctrl: cell memory model, motion-update sink,
// scoreboards for the vel_out handshakes and memory writes, directed tests.
module tb_velocity_cell_ctrl;
  localparam int DW     = 96;
  localparam int AW     = 8;
  localparam int PN     = 220;
  localparam int RD_LAT = 2;
  localparam int W      = AW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, count_err;
  logic [3:0] state_dbg;

  velocity_cell_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  velocity_cell_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .count_err(count_err), .state_dbg(state_dbg), .bus(bus)
  );

  // clock
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_vo_q[$];
  logic [W-1:0] exp_wr_q[$];
  int done_cnt = 0, done_cyc = -1, ack_cyc = -1, vo_cycles = 0, wr_cnt = 0;
  int stable_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic vin_pending = 1'b0;
  int ready_hold = 0, vin_delay = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // cell memory model with RD_LAT read latency
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe [RD_LAT];
  assign bus.mem_q = pipe[RD_LAT-1];
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {32'(a + 300), 32'(a + 200), 32'(a)};
    for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
    forever begin
      @(posedge clk);
      for (int k = RD_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= bus.mem_rden ? mem[bus.mem_address] : {3{32'hdead_beef}};
      if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
    end
  end

  // motion-update sink: accepts vel_out, returns vel_out+1 on vel_in
  initial begin
    int sk, hold, dly;
    logic [DW-1:0] snap_v;
    logic [AW-1:0] snap_id;
    sk = 0; hold = 0; dly = 0; snap_v = '0; snap_id = '0;
    bus.vel_out_ready = 1'b0;
    bus.vel_in_valid  = 1'b0;
    bus.vel_in        = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        sk = 0;
        bus.vel_out_ready = 1'b0;
        bus.vel_in_valid  = 1'b0;
        vin_pending       = 1'b0;
      end else begin
        case (sk)
          0: if (bus.vel_out_valid) begin
               snap_v = bus.vel_out; snap_id = bus.vel_out_id; hold = 1;
               if (ready_hold == 0) begin bus.vel_out_ready = 1'b1; sk = 1; end
               else sk = 2;
             end
          2: begin
               stable_cnt++;
               check("vel_out_stable", {bus.vel_out_valid, bus.vel_out_id, bus.vel_out},
                     {1'b1, snap_id, snap_v});
               if (hold == ready_hold) begin bus.vel_out_ready = 1'b1; sk = 1; end
               else hold++;
             end
          1: begin
               bus.vel_out_ready = 1'b0; vin_pending = 1'b1; dly = 0; sk = 4;
             end
          4: begin
               if (dly >= vin_delay) begin
                 bus.vel_in = snap_v + 1; bus.vel_in_valid = 1'b1;
                 sk = bus.vel_in_ready ? 5 : 3;
               end else dly++;
             end
          3: if (bus.vel_in_ready) sk = 5;
          5: begin bus.vel_in_valid = 1'b0; vin_pending = 1'b0; sk = 0; end
          default: sk = 0;
        endcase
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rden || bus.mem_wren) check("strobe_excl", bus.mem_rden & bus.mem_wren, 0);
      if (bus.vel_out_valid) vo_cycles++;
      if (bus.vel_out_valid && bus.vel_out_ready) begin
        if (exp_vo_q.size() == 0) check("unexpected_vel_out", {bus.vel_out_id, bus.vel_out}, 0);
        else check("vel_out", {bus.vel_out_id, bus.vel_out}, exp_vo_q.pop_front());
      end
      if (bus.mem_wren) begin
        wr_cnt++;
        last_wr_addr = bus.mem_address;
        check("write_before_capture", vin_pending, 0);
        if (exp_wr_q.size() == 0) check("unexpected_write", {bus.mem_address, bus.mem_data}, 0);
        else check("mem_write", {bus.mem_address, bus.mem_data}, exp_wr_q.pop_front());
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      if (bus.host_wr_ack) begin
        ack_cyc = cyc;
        check("ack_while_busy", busy, 0);
      end
    end
  end

  // driver tasks
  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_start);
    int n;
    exp_wr_q.push_back({a, d});
    bus.host_wr_req = 1'b1; bus.host_addr = a; bus.host_data = d;
    if (with_start) start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      start = 1'b0;
    end while (!bus.host_wr_ack && n < 300);
    check("host_ack", bus.host_wr_ack, 1);
    bus.host_wr_req = 1'b0;
  endtask

  task automatic pulse_start(output int s_cyc);
    start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < bound) begin @(posedge clk); #1; n++; end
    check("done_seen", (done_cnt != d0), 1);
  endtask

  task automatic check_rst();
    check("rst_flags", {busy, done, count_err, bus.host_wr_ack, bus.mem_rden, bus.mem_wren,
                        bus.vel_out_valid, bus.vel_in_ready}, 0);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_mem_data", bus.mem_data, 0);
    check("rst_vel_out", bus.vel_out, 0);
    check("rst_vel_out_id", bus.vel_out_id, 0);
    check("rst_state", state_dbg, 0);
  endtask

  task automatic push_pass(input int n);
    for (int i = 1; i <= n; i++) begin
      exp_vo_q.push_back({AW'(i), mem[i]});
      exp_wr_q.push_back({AW'(i), mem[i] + 1});
    end
  endtask

  localparam logic [DW-1:0] V1  = 96'h0000000a_00000014_0000001e;
  localparam logic [DW-1:0] V2  = 96'h00000028_00000032_0000003c;
  localparam logic [DW-1:0] V3  = 96'h00000046_00000050_0000005a;
  localparam logic [DW-1:0] V1P = 96'h0000000a_00000014_0000001f;
  localparam logic [DW-1:0] V2P = 96'h00000028_00000032_0000003d;
  localparam logic [DW-1:0] V3P = 96'h00000046_00000050_0000005b;

  initial begin
    int s, d0, base_vo, base_wr, st0, n;
    bus.host_wr_req = 1'b0; bus.host_addr = '0; bus.host_data = '0;
    repeat (3) @(posedge clk); #1;
    check_rst();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three particles, sink always ready
    host_write(8'd0, 96'd3, 1'b0);
    host_write(8'd1, V1, 1'b0);
    host_write(8'd2, V2, 1'b0);
    host_write(8'd3, V3, 1'b0);
    exp_vo_q.push_back({8'd1, V1}); exp_wr_q.push_back({8'd1, V1P});
    exp_vo_q.push_back({8'd2, V2}); exp_wr_q.push_back({8'd2, V2P});
    exp_vo_q.push_back({8'd3, V3}); exp_wr_q.push_back({8'd3, V3P});
    d0 = done_cnt;
    pulse_start(s);
    wait_done(300);
    repeat (3) @(posedge clk); #1;
    check("pass3_done_pulses", done_cnt - d0, 1);
    check("pass3_count_err", count_err, 0);
    check("pass3_mem1", mem[1], V1P);
    check("pass3_mem2", mem[2], V2P);
    check("pass3_mem3", mem[3], V3P);

    // empty cell: done RD_LAT+2 cycles after start, no traffic
    host_write(8'd0, 96'd0, 1'b0);
    @(posedge clk); #1;
    base_vo = vo_cycles; base_wr = wr_cnt;
    pulse_start(s);
    wait_done(50);
    check("empty_done_latency", done_cyc - s, RD_LAT + 2);
    check("empty_no_vel_out", vo_cycles - base_vo, 0);
    check("empty_no_write", wr_cnt - base_wr, 0);

    // count above capacity is clamped
    host_write(8'd0, 96'd250, 1'b0);
    @(posedge clk); #1;
    push_pass(PN - 1);
    pulse_start(s);
    wait_done(5000);
    check("clamp_count_err", count_err, 1);
    check("clamp_last_addr", last_wr_addr, 8'd219);

    // backpressure on vel_out and a late vel_in
    host_write(8'd0, 96'd1, 1'b0);
    @(posedge clk); #1;
    ready_hold = 5; vin_delay = 3;
    st0 = stable_cnt;
    push_pass(1);
    pulse_start(s);
    wait_done(300);
    check("hold_stable_cycles", stable_cnt - st0, 5);
    check("err_sticky", count_err, 1);
    ready_hold = 0; vin_delay = 0;

    // host request during a pass waits until done
    host_write(8'd0, 96'd2, 1'b0);
    @(posedge clk); #1;
    push_pass(2);
    pulse_start(s);
    repeat (3) @(posedge clk); #1;
    host_write(8'd10, 96'h55, 1'b0);
    @(posedge clk); #1;
    check("pending_ack_cycle", ack_cyc - done_cyc, 1);
    check("pending_write_mem", mem[10], 96'h55);

    // start together with a host request: write happens, start dropped
    d0 = done_cnt;
    host_write(8'd11, 96'h66, 1'b1);
    repeat (8) @(posedge clk); #1;
    check("start_ignored_busy", busy, 0);
    check("start_ignored_done", done_cnt - d0, 0);
    check("start_ignored_state", state_dbg, 0);
    check("start_ignored_mem", mem[11], 96'h66);

    // reset during RECV of particle 2, then a fresh pass
    host_write(8'd0, 96'd3, 1'b0);
    @(posedge clk); #1;
    vin_delay = 3;
    exp_vo_q.push_back({8'd1, mem[1]});
    exp_wr_q.push_back({8'd1, mem[1] + 1});
    exp_vo_q.push_back({8'd2, mem[2]});
    pulse_start(s);
    n = 0;
    while (!(bus.vel_in_ready && bus.vel_out_id == 8'd2) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("reached_recv2", {bus.vel_in_ready, bus.vel_out_id}, {1'b1, 8'd2});
    #2 rst_n = 1'b0;
    #1 check_rst();
    check("queues_at_reset", exp_vo_q.size() + exp_wr_q.size(), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    vin_delay = 0;
    @(posedge clk); #1;
    push_pass(3);
    pulse_start(s);
    wait_done(300);
    repeat (2) @(posedge clk); #1;
    check("final_queues_empty", exp_vo_q.size() + exp_wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
